clz_restore: RTL and testbench

// - Inverse of the leading-zero counter: takes a normalised value (leading one shifted to MSB)

---
 rtl/clz_restore.sv | 121 ++++++++++++
 tb/tb_clz_restore.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clz_restore.sv
// Pipelined right-shifter that undoes leading-zero normalisation: out_data = in_norm >> in_count.
// Optional travelling sticky bit (OR of shifted-out bits) when CLZ_RESTORE_STICKY_EN is defined.
module clz_restore #(
    parameter  int bits_in  = 16,
    localparam int bits_out = $clog2(bits_in)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bits_in-1:0]  in_norm,
    input  logic [bits_out-1:0] in_count,
    input  logic                in_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [bits_in-1:0]  out_data,
    output logic [bits_in-1:0]  out_onehot
`ifdef CLZ_RESTORE_STICKY_EN
    ,
    output logic                out_sticky
`endif
);
    localparam int NS = bits_out - 1;
    localparam logic [bits_in-1:0] MSB_ONE = {1'b1, {(bits_in-1){1'b0}}};

    // Stages 0..NS-1 are internal; stage NS is the output register set.
    logic [NS-1:0]       r_vld;
    logic [NS-1:0]       r_zero;
    logic [bits_in-1:0]  r_data [NS];
    logic [bits_out-1:0] r_cnt  [NS];

    logic                r_out_valid;
    logic [bits_in-1:0]  r_out_data;
    logic [bits_in-1:0]  r_out_onehot;

    logic                w_advance;
    logic                w_keep;
    logic [bits_out-1:0] w_src_vld;
    logic [bits_out-1:0] w_src_zero;
    logic [bits_in-1:0]  w_src_data   [bits_out];
    logic [bits_out-1:0] w_src_cnt    [bits_out];
    logic [bits_in-1:0]  w_shift_data [bits_out];

`ifdef CLZ_RESTORE_STICKY_EN
    logic [NS-1:0]       r_stk;
    logic                r_out_sticky;
    logic [bits_out-1:0] w_src_stk;
    logic [bits_out-1:0] w_shift_stk;
`endif

    assign w_advance = ~r_out_valid | out_ready;
    assign in_ready  = w_advance & ~rst;

    always_comb begin
        w_src_vld[0]  = in_valid;
        w_src_zero[0] = in_zero;
        w_src_data[0] = in_norm;
        w_src_cnt[0]  = in_count;
        for (int k = 1; k < bits_out; k++) begin
            w_src_vld[k]  = r_vld[k-1];
            w_src_zero[k] = r_zero[k-1];
            w_src_data[k] = r_data[k-1];
            w_src_cnt[k]  = r_cnt[k-1];
        end
        for (int k = 0; k < bits_out; k++) begin
            w_shift_data[k] = w_src_cnt[k][k] ? (w_src_data[k] >> (1 << k)) : w_src_data[k];
        end
    end

`ifdef CLZ_RESTORE_STICKY_EN
    always_comb begin
        w_src_stk[0] = 1'b0;
        for (int k = 1; k < bits_out; k++) begin
            w_src_stk[k] = r_stk[k-1];
        end
        for (int k = 0; k < bits_out; k++) begin
            w_shift_stk[k] = w_src_stk[k] | (w_src_cnt[k][k] &
                             (|(w_src_data[k] & ~({bits_in{1'b1}} << (1 << k)))));
        end
    end
`endif

    // Zero operands and bubbles leave the output registers cleared.
    assign w_keep = w_src_vld[NS] & ~w_src_zero[NS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_onehot <= '0;
`ifdef CLZ_RESTORE_STICKY_EN
            r_out_sticky <= 1'b0;
`endif
        end else if (w_advance) begin
            for (int k = 0; k < NS; k++) begin
                r_vld[k]  <= w_src_vld[k];
                r_zero[k] <= w_src_zero[k];
                r_data[k] <= w_shift_data[k];
                r_cnt[k]  <= w_src_cnt[k];
`ifdef CLZ_RESTORE_STICKY_EN
                r_stk[k]  <= w_shift_stk[k];
`endif
            end
            r_out_valid  <= w_src_vld[NS];
            r_out_data   <= w_keep ? w_shift_data[NS] : '0;
            r_out_onehot <= w_keep ? (MSB_ONE >> w_src_cnt[NS]) : '0;
`ifdef CLZ_RESTORE_STICKY_EN
            r_out_sticky <= w_keep & w_shift_stk[NS];
`endif
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_onehot = r_out_onehot;
`ifdef CLZ_RESTORE_STICKY_EN
    assign out_sticky = r_out_sticky;
`endif

endmodule

// File: tb/tb_clz_restore.sv
// Directed self-checking bench for clz_restore (bits_in=16); sticky checks compiled
// only when CLZ_RESTORE_STICKY_EN is defined.
module tb_clz_restore;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_norm = '0;
    logic [3:0]  in_count = '0;
    logic        in_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [15:0] out_onehot;
    logic        tb_sticky;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clz_restore #(.bits_in(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_norm    (in_norm),
        .in_count   (in_count),
        .in_zero    (in_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_onehot (out_onehot)
`ifdef CLZ_RESTORE_STICKY_EN
        ,
        .out_sticky (tb_sticky)
`endif
    );
`ifndef CLZ_RESTORE_STICKY_EN
    assign tb_sticky = 1'b0;
`endif

    // Drives one transaction and waits (bounded) for its result; lat=-1 on timeout.
    task automatic send_one(input logic [15:0] n, input logic [3:0] c, input logic z,
                            output logic [15:0] d, output logic [15:0] oh,
                            output logic s, output int lat);
        d = '0; oh = '0; s = 1'b0; lat = -1;
        @(negedge clk);
        in_valid = 1'b1; in_norm = n; in_count = c; in_zero = z;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (out_valid) begin
                lat = i; d = out_data; oh = out_onehot; s = tb_sticky;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++; if (out_onehot !== 16'h0) begin errors++; $display("FAIL reset_out_onehot got=%h exp=0000", out_onehot); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [15:0] d, oh; logic s; int lat;
        send_one(16'h8000, 4'd3, 1'b0, d, oh, s, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        checks++; if (d !== 16'h1000) begin errors++; $display("FAIL basic_data got=%h exp=1000", d); end
        checks++; if (oh !== 16'h1000) begin errors++; $display("FAIL basic_onehot got=%h exp=1000", oh); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_onehot !== 16'h0) begin
            errors++; $display("FAIL idle_outputs_zero got v=%b d=%h oh=%h exp v=0 d=0000 oh=0000", out_valid, out_data, out_onehot);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] d, oh; logic s; int lat;
        send_one(16'hA5A5, 4'd0, 1'b0, d, oh, s, lat);
        checks++; if (d !== 16'hA5A5) begin errors++; $display("FAIL count0_data got=%h exp=a5a5", d); end
        checks++; if (oh !== 16'h8000) begin errors++; $display("FAIL count0_onehot got=%h exp=8000", oh); end
        send_one(16'h8000, 4'd15, 1'b0, d, oh, s, lat);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL count15_data got=%h exp=0001", d); end
        checks++; if (oh !== 16'h0001) begin errors++; $display("FAIL count15_onehot got=%h exp=0001", oh); end
        send_one(16'h0F0F, 4'd4, 1'b0, d, oh, s, lat);
        checks++; if (d !== 16'h00F0) begin errors++; $display("FAIL msb_clear_data got=%h exp=00f0", d); end
        checks++; if (oh !== 16'h0800) begin errors++; $display("FAIL msb_clear_onehot got=%h exp=0800", oh); end
    endtask

    task automatic test_zero_flag();
        logic [15:0] d, oh; logic s; int lat;
        send_one(16'hFFFF, 4'd2, 1'b1, d, oh, s, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL zero_latency got=%0d exp=4", lat); end
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL zero_data got=%h exp=0000", d); end
        checks++; if (oh !== 16'h0) begin errors++; $display("FAIL zero_onehot got=%h exp=0000", oh); end
`ifdef CLZ_RESTORE_STICKY_EN
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL zero_sticky got=%b exp=0", s); end
`endif
    endtask

`ifdef CLZ_RESTORE_STICKY_EN
    task automatic test_sticky();
        logic [15:0] d, oh; logic s; int lat;
        send_one(16'hC001, 4'd4, 1'b0, d, oh, s, lat);
        checks++; if (d !== 16'h0C00) begin errors++; $display("FAIL sticky_data got=%h exp=0c00", d); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL sticky_set got=%b exp=1", s); end
        send_one(16'hC000, 4'd4, 1'b0, d, oh, s, lat);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%b exp=0", s); end
        send_one(16'hFFFF, 4'd0, 1'b0, d, oh, s, lat);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL sticky_count0 got=%b exp=0", s); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [15:0] bn [6];
        logic [3:0]  bc [6];
        logic [15:0] ed [6];
        logic [15:0] eo [6];
        logic [15:0] held_d, held_oh;
        int sent = 0, recv = 0, stall_left = 0;
        bit stall_started = 0;
        bn[0] = 16'hF000; bc[0] = 4'd1;  ed[0] = 16'h7800; eo[0] = 16'h4000;
        bn[1] = 16'h8001; bc[1] = 4'd4;  ed[1] = 16'h0800; eo[1] = 16'h0800;
        bn[2] = 16'hABCD; bc[2] = 4'd8;  ed[2] = 16'h00AB; eo[2] = 16'h0080;
        bn[3] = 16'h9000; bc[3] = 4'd2;  ed[3] = 16'h2400; eo[3] = 16'h2000;
        bn[4] = 16'hFFFF; bc[4] = 4'd15; ed[4] = 16'h0001; eo[4] = 16'h0001;
        bn[5] = 16'hC3C3; bc[5] = 4'd0;  ed[5] = 16'hC3C3; eo[5] = 16'h8000;
        held_d = '0; held_oh = '0;
        for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
            @(negedge clk);
            if (out_valid && !stall_started) begin stall_started = 1; stall_left = 3; end
            out_ready = !(stall_left > 0);
            if (sent < 6) begin
                in_valid = 1'b1; in_norm = bn[sent]; in_count = bc[sent]; in_zero = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
                if (stall_left == 3) begin
                    held_d = out_data; held_oh = out_onehot;
                end else begin
                    checks++; if (out_valid !== 1'b1 || out_data !== held_d || out_onehot !== held_oh) begin
                        errors++; $display("FAIL stall_hold got v=%b d=%h oh=%h exp v=1 d=%h oh=%h", out_valid, out_data, out_onehot, held_d, held_oh);
                    end
                end
                stall_left--;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checks++; if (out_data !== ed[recv] || out_onehot !== eo[recv]) begin
                    errors++; $display("FAIL b2b_result_%0d got d=%h oh=%h exp d=%h oh=%h", recv, out_data, out_onehot, ed[recv], eo[recv]);
                end
                recv++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (recv !== 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", recv); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_norm = 16'hFFFF; in_count = 4'(i + 1); in_zero = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
        in_valid = 1'b1; in_norm = 16'hF000; in_count = 4'd4; in_zero = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_accept got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                seen++;
                checks++; if (out_data !== 16'h0F00) begin errors++; $display("FAIL rst_mid_data got=%h exp=0f00", out_data); end
            end
            @(negedge clk);
        end
        checks++; if (seen !== 1) begin errors++; $display("FAIL rst_mid_emerged got=%0d exp=1", seen); end
    endtask

    task automatic test_round_trip();
        localparam int N = 10000;
        logic [15:0] q [$];
        logic [15:0] x, xn, exp_x, exp_oh;
        logic [3:0]  cnt;
        int i = 0, got = 0;
        out_ready = 1'b1;
        x = 16'h0;
        for (int cyc = 0; cyc < N + 100 && got < N; cyc++) begin
            @(negedge clk);
            if (i < N) begin
                cnt = 4'd0;
                for (int b = 15; b >= 0; b--) begin
                    if (x[b]) break;
                    cnt++;
                end
                xn = (x == 16'h0) ? 16'h0 : (x << cnt);
                in_valid = 1'b1; in_norm = xn; in_count = (x == 16'h0) ? 4'd0 : cnt; in_zero = (x == 16'h0);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL round_trip_spurious got d=%h exp no output", out_data);
                end else begin
                    exp_x = q.pop_front();
                    exp_oh = 16'h0;
                    for (int b = 15; b >= 0; b--) begin
                        if (exp_x[b]) begin exp_oh[b] = 1'b1; break; end
                    end
                    checks++; if (out_data !== exp_x || out_onehot !== exp_oh) begin
                        errors++; $display("FAIL round_trip got d=%h oh=%h exp d=%h oh=%h", out_data, out_onehot, exp_x, exp_oh);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(x);
                i++;
                if (i == 1) x = 16'hFFFF;
                else if (i == 2) x = 16'h0001;
                else x = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            end
        end
        in_valid = 1'b0;
        checks++; if (got !== N) begin errors++; $display("FAIL round_trip_count got=%0d exp=%0d", got, N); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_zero_flag();
`ifdef CLZ_RESTORE_STICKY_EN
        test_sticky();
`endif
        test_back_to_back();
        test_reset_mid();
        test_round_trip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
